mul_seq_ctrl: RTL and testbench
===============================

MUL_SEQ_CTRL -- requirements
Module: mul_seq_ctrl

Interface
REQ-001 SHALL have parameter WIDTH, default 32, operand width; 32 is the only supported value.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port start_valid  input  1  requester presents an operand pair.
REQ-005 SHALL have port start_ready  output  1  block can accept an operand pair.
REQ-006 SHALL have port a  input  32  multiplicand, unsigned.
REQ-007 SHALL have port b  input  32  multiplier, unsigned.
REQ-008 SHALL have port res_valid  output  1  product is available.
REQ-009 SHALL have port res_ready  input  1  consumer accepts the product.
REQ-010 SHALL have port product  output  64  unsigned a*b.
REQ-011 SHALL have port busy  output  1  high in RUN or DONE.

Function
REQ-012 SHALL implement FSM states IDLE, RUN, DONE.
REQ-013 SHALL drive start_ready high only in IDLE; start_valid in RUN/DONE is ignored and has no side effect.
REQ-014 SHALL, on an edge with IDLE and start_valid, latch a into mcand, clear hi[31:0], load lo[31:0]=b, load iteration count 0, and enter RUN.
REQ-015 SHALL per RUN cycle: sum,cout = hi + (lo[0] ? mcand : 0) through one shared 32-bit adder with carry-in 0; then {hi,lo} <= {cout,sum,lo[31:1]}; count increments.
REQ-016 SHALL perform exactly 32 iterations (count 0..31), and enter DONE on the edge that completes iteration 31.
REQ-017 SHALL assert res_valid only in DONE, with product={hi,lo} registered; latency is 32 edges from acceptance edge to first res_valid cycle.
REQ-018 SHALL hold product and res_valid stable while res_valid && !res_ready (any stall length).
REQ-019 SHALL return to IDLE on the edge where res_valid && res_ready; start_ready rises the cycle after (one bubble between jobs, no overlap).
REQ-020 SHALL compute full 64-bit unsigned products without overflow; adder carry-out is captured into the shifted accumulator every iteration.
REQ-021 SHALL not short-circuit zero operands; latency stays 32 regardless of data.
REQ-022 SHALL drive busy = (state != IDLE).

Reset
REQ-023 SHALL, on rst high, asynchronously force state=IDLE, count=0, hi=0, lo=0, mcand=0, product=0, res_valid=0, busy=0, start_ready=1 (after release).
REQ-024 SHALL, on reset asserted mid-RUN or in DONE, discard the job; no res_valid is produced for it.
REQ-025 SHALL accept a new start_valid on the first rising edge after rst deasserts.

Structure
REQ-026 SHALL place the state enum (IDLE/RUN/DONE) and constant ITERATIONS=32 in shared package mul_seq_pkg.
REQ-027 SHALL instantiate exactly one sub-module, the team's 32-bit ripple adder fulladderN, as the only arithmetic resource; no '*' operator.
REQ-028 SHALL keep the FSM, counter, and accumulator registers in mul_seq_ctrl itself.

Verification
REQ-029 SHALL cover: a=3, b=5, res_ready=1 -> res_valid exactly 32 edges after acceptance, product=0x0000_0000_0000_000F.
REQ-030 SHALL cover: a=b=0xFFFF_FFFF -> product=0xFFFF_FFFE_0000_0001 (carry-out path exercised).
REQ-031 SHALL cover: a=0x1234_5678, b=0x9ABC_DEF0, res_ready low 10 cycles -> product=0x0B00_EA4E_242D_2080 constant, res_valid high all 10 cycles, IDLE one edge after res_ready rises.
REQ-032 SHALL cover: rst pulsed at iteration 10 -> busy=0 and res_valid=0 immediately; next job a=7, b=6 -> product=42.
REQ-033 SHALL cover: start_valid held high with changing a/b during RUN -> result reflects only the accepted pair; next pair is accepted only once back in IDLE.
REQ-034 SHALL cover: a=0, b=0xFFFF_FFFF -> product=0, latency still 32.

Source files
------------

// File: rtl/mul_seq_pkg.sv
// Shared types and constants for the sequential shift-add multiplier.
package mul_seq_pkg;
  localparam int ITERATIONS = 32;
  localparam int CNT_W      = $clog2(ITERATIONS);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;
endpackage

// File: rtl/fulladderN.sv
// Parameterised ripple-carry adder built from a chain of full-adder cells.
module fulladderN #(
  parameter int N = 32
) (
  input  logic [N-1:0] a_i,
  input  logic [N-1:0] b_i,
  input  logic         cin_i,
  output logic [N-1:0] sum_o,
  output logic         cout_o
);
  logic [N:0] c;

  always_comb begin
    c     = '0;
    sum_o = '0;
    c[0]  = cin_i;
    for (int i = 0; i < N; i++) begin
      sum_o[i] = a_i[i] ^ b_i[i] ^ c[i];
      c[i+1]   = (a_i[i] & b_i[i]) | (c[i] & (a_i[i] ^ b_i[i]));
    end
  end

  assign cout_o = c[N];
endmodule

// File: rtl/mul_seq_ctrl.sv
// Sequential 32x32 unsigned shift-add multiplier with valid/ready handshakes
// on both the operand and result sides; one shared ripple adder does all math.
module mul_seq_ctrl
  import mul_seq_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start_valid,
  output logic               start_ready,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               res_valid,
  input  logic               res_ready,
  output logic [2*WIDTH-1:0] product,
  output logic               busy
);
  state_e           state_q, state_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;

  logic [WIDTH-1:0] addend;
  logic [WIDTH-1:0] sum;
  logic             cout;

  assign addend = lo_q[0] ? mcand_q : '0;

  fulladderN #(.N(WIDTH)) u_adder (
    .a_i    (hi_q),
    .b_i    (addend),
    .cin_i  (1'b0),
    .sum_o  (sum),
    .cout_o (cout)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      count_q <= '0;
      mcand_q <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      mcand_q <= mcand_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    mcand_d = mcand_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    unique case (state_q)
      IDLE: begin
        if (start_valid) begin
          mcand_d = a;
          hi_d    = '0;
          lo_d    = b;
          count_d = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        // Carry-out becomes the new MSB so the 64-bit product never overflows.
        {hi_d, lo_d} = {cout, sum, lo_q[WIDTH-1:1]};
        count_d      = count_q + 1'b1;
        if (count_q == CNT_W'(ITERATIONS - 1)) state_d = DONE;
      end
      DONE: begin
        if (res_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign start_ready = (state_q == IDLE);
  assign res_valid   = (state_q == DONE);
  assign busy        = (state_q != IDLE);
  assign product     = {hi_q, lo_q};
endmodule

// File: tb/tb_mul_seq_ctrl.sv
// Directed testbench for mul_seq_ctrl: latency, products, stalls, reset abort, overlap.
module tb_mul_seq_ctrl;
  logic        clk = 1'b0;
  logic        rst;
  logic        start_valid;
  logic        start_ready;
  logic [31:0] a;
  logic [31:0] b;
  logic        res_valid;
  logic        res_ready;
  logic [63:0] product;
  logic        busy;

  int pass_cnt  = 0;
  int total_cnt = 0;

  always #5 clk = ~clk;

  mul_seq_ctrl #(.WIDTH(32)) dut (
    .clk         (clk),
    .rst         (rst),
    .start_valid (start_valid),
    .start_ready (start_ready),
    .a           (a),
    .b           (b),
    .res_valid   (res_valid),
    .res_ready   (res_ready),
    .product     (product),
    .busy        (busy)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Present one operand pair, then count edges until res_valid (bounded at 100).
  task automatic run_job(input logic [31:0] av, input logic [31:0] bv, output int lat);
    start_valid = 1'b1;
    a = av;
    b = bv;
    tick;
    start_valid = 1'b0;
    lat = 0;
    while (!res_valid && lat < 100) begin
      tick;
      lat++;
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    start_valid = 1'b0;
    res_ready = 1'b0;
    a = '0;
    b = '0;
    #3;
    total_cnt++; if (busy !== 1'b0) $display("FAIL rst_busy got %b want 0", busy); else pass_cnt++;
    total_cnt++; if (res_valid !== 1'b0) $display("FAIL rst_res_valid got %b want 0", res_valid); else pass_cnt++;
    total_cnt++; if (product !== 64'h0) $display("FAIL rst_product got %h want 0", product); else pass_cnt++;
    tick;
    tick;
    rst = 1'b0;
    #2;
    total_cnt++; if (start_ready !== 1'b1) $display("FAIL rst_start_ready got %b want 1", start_ready); else pass_cnt++;
  endtask

  task automatic test_basic;
    int lat;
    res_ready = 1'b1;
    run_job(32'd3, 32'd5, lat);
    total_cnt++; if (lat !== 32) $display("FAIL basic_latency got %0d want 32", lat); else pass_cnt++;
    total_cnt++; if (product !== 64'h0000_0000_0000_000F) $display("FAIL basic_product got %h want 000000000000000f", product); else pass_cnt++;
    total_cnt++; if (start_ready !== 1'b0) $display("FAIL basic_done_start_ready got %b want 0", start_ready); else pass_cnt++;
    total_cnt++; if (busy !== 1'b1) $display("FAIL basic_done_busy got %b want 1", busy); else pass_cnt++;
    tick;
    total_cnt++; if (res_valid !== 1'b0) $display("FAIL basic_after_res_valid got %b want 0", res_valid); else pass_cnt++;
    total_cnt++; if (start_ready !== 1'b1) $display("FAIL basic_after_start_ready got %b want 1", start_ready); else pass_cnt++;
  endtask

  task automatic test_all_ones;
    int lat;
    res_ready = 1'b1;
    run_job(32'hFFFF_FFFF, 32'hFFFF_FFFF, lat);
    total_cnt++; if (lat !== 32) $display("FAIL ones_latency got %0d want 32", lat); else pass_cnt++;
    total_cnt++; if (product !== 64'hFFFF_FFFE_0000_0001) $display("FAIL ones_product got %h want fffffffe00000001", product); else pass_cnt++;
    tick;
  endtask

  task automatic test_stall;
    int lat;
    res_ready = 1'b0;
    run_job(32'h1234_5678, 32'h9ABC_DEF0, lat);
    total_cnt++; if (lat !== 32) $display("FAIL stall_latency got %0d want 32", lat); else pass_cnt++;
    for (int i = 0; i < 10; i++) begin
      total_cnt++; if (res_valid !== 1'b1) $display("FAIL stall_res_valid cycle %0d got %b want 1", i, res_valid); else pass_cnt++;
      total_cnt++; if (product !== 64'h0B00_EA4E_242D_2080) $display("FAIL stall_product cycle %0d got %h want 0b00ea4e242d2080", i, product); else pass_cnt++;
      tick;
    end
    res_ready = 1'b1;
    tick;
    total_cnt++; if (start_ready !== 1'b1) $display("FAIL stall_release_start_ready got %b want 1", start_ready); else pass_cnt++;
    total_cnt++; if (res_valid !== 1'b0) $display("FAIL stall_release_res_valid got %b want 0", res_valid); else pass_cnt++;
  endtask

  task automatic test_reset_mid;
    int lat;
    res_ready = 1'b1;
    start_valid = 1'b1;
    a = 32'h1234_5678;
    b = 32'h9ABC_DEF0;
    tick;
    start_valid = 1'b0;
    repeat (10) tick;
    total_cnt++; if (busy !== 1'b1) $display("FAIL midrst_pre_busy got %b want 1", busy); else pass_cnt++;
    #1 rst = 1'b1;
    #1;
    total_cnt++; if (busy !== 1'b0) $display("FAIL midrst_busy got %b want 0", busy); else pass_cnt++;
    total_cnt++; if (res_valid !== 1'b0) $display("FAIL midrst_res_valid got %b want 0", res_valid); else pass_cnt++;
    total_cnt++; if (product !== 64'h0) $display("FAIL midrst_product got %h want 0", product); else pass_cnt++;
    #1 rst = 1'b0;
    run_job(32'd7, 32'd6, lat);
    total_cnt++; if (lat !== 32) $display("FAIL midrst_next_latency got %0d want 32", lat); else pass_cnt++;
    total_cnt++; if (product !== 64'd42) $display("FAIL midrst_next_product got %0d want 42", product); else pass_cnt++;
    tick;
  endtask

  task automatic test_back_to_back;
    int lat;
    res_ready = 1'b1;
    start_valid = 1'b1;
    a = 32'h10;
    b = 32'h20;
    tick;
    lat = 0;
    while (!res_valid && lat < 100) begin
      a = 32'(lat) + 32'h100;
      b = 32'hFFFF;
      if (lat == 5) begin
        total_cnt++; if (start_ready !== 1'b0) $display("FAIL b2b_run_start_ready got %b want 0", start_ready); else pass_cnt++;
      end
      tick;
      lat++;
    end
    total_cnt++; if (lat !== 32) $display("FAIL b2b_latency got %0d want 32", lat); else pass_cnt++;
    total_cnt++; if (product !== 64'h200) $display("FAIL b2b_product got %h want 0000000000000200", product); else pass_cnt++;
    a = 32'd9;
    b = 32'd11;
    tick;
    total_cnt++; if (busy !== 1'b0) $display("FAIL b2b_idle_busy got %b want 0", busy); else pass_cnt++;
    total_cnt++; if (start_ready !== 1'b1) $display("FAIL b2b_idle_start_ready got %b want 1", start_ready); else pass_cnt++;
    tick;
    start_valid = 1'b0;
    total_cnt++; if (busy !== 1'b1) $display("FAIL b2b_second_accept got %b want 1", busy); else pass_cnt++;
    lat = 0;
    while (!res_valid && lat < 100) begin
      tick;
      lat++;
    end
    total_cnt++; if (lat !== 32) $display("FAIL b2b_second_latency got %0d want 32", lat); else pass_cnt++;
    total_cnt++; if (product !== 64'd99) $display("FAIL b2b_second_product got %0d want 99", product); else pass_cnt++;
    tick;
  endtask

  task automatic test_zero;
    int lat;
    res_ready = 1'b1;
    run_job(32'h0, 32'hFFFF_FFFF, lat);
    total_cnt++; if (lat !== 32) $display("FAIL zero_latency got %0d want 32", lat); else pass_cnt++;
    total_cnt++; if (product !== 64'h0) $display("FAIL zero_product got %h want 0", product); else pass_cnt++;
    tick;
    total_cnt++; if (busy !== 1'b0) $display("FAIL zero_after_busy got %b want 0", busy); else pass_cnt++;
  endtask

  initial begin
    test_reset;
    test_basic;
    test_all_ones;
    test_stall;
    test_reset_mid;
    test_back_to_back;
    test_zero;
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
